// File: rtl/uart_rx_cfg_if.sv
// Stream-side bundle of the configurable UART receiver: one received word
// plus its per-frame flags, and the consumer's ready.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 break_det;
  logic                 overrun;

  modport master (
    output m_data, m_valid, frame_err, parity_err, break_det, overrun,
    input  m_ready
  );

  modport slave (
    input  m_data, m_valid, frame_err, parity_err, break_det, overrun,
    output m_ready
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver with majority-vote bit decisions,
// break detection and a single-entry output register that reports overruns.
module uart_rx_cfg #(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVR        = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rx,
  uart_rx_cfg_if.master  m_if
);

  localparam int DIV   = CLOCK_RATE / (BAUD_RATE * OVR);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SC_W  = $clog2(OVR);
  localparam int BC_W  = $clog2(DATA_BITS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [SC_W-1:0]  SMP_A     = SC_W'(OVR / 2 - 1);
  localparam logic [SC_W-1:0]  SMP_B     = SC_W'(OVR / 2);
  localparam logic [SC_W-1:0]  SMP_DEC   = SC_W'(OVR / 2 + 1);
  localparam logic [SC_W-1:0]  SMP_LAST  = SC_W'(OVR - 1);
  localparam logic [BC_W-1:0]  DATA_LAST = BC_W'(DATA_BITS - 1);
  localparam logic [BC_W-1:0]  STOP_LAST = BC_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK
  } state_t;

  state_t               state_q, state_d;
  logic                 rxMeta_q, rxs_q;
  logic [DIV_W-1:0]     divCnt_q, divCnt_d;
  logic [SC_W-1:0]      sampCnt_q, sampCnt_d;
  logic [BC_W-1:0]      bitCnt_q, bitCnt_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parErr_q, parErr_d;
  logic                 frameErr_q, frameErr_d;
  logic                 brk_q, brk_d;
  logic                 allZero_q, allZero_d;
  logic [DATA_BITS-1:0] outData_q, outData_d;
  logic                 outValid_q, outValid_d;
  logic                 outFe_q, outFe_d;
  logic                 outPe_q, outPe_d;
  logic                 outBrk_q, outBrk_d;
  logic                 overrun_q, overrun_d;

  logic tick, decide, wrap, maj;
  logic done, doneFe, doneBrk;

  assign tick   = (divCnt_q == DIV_LAST);
  assign decide = tick && (sampCnt_q == SMP_DEC);
  assign wrap   = tick && (sampCnt_q == SMP_LAST);
  // Third vote is the live synchronised line at the decision tick.
  assign maj    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rxMeta_q   <= 1'b1;
      rxs_q      <= 1'b1;
      divCnt_q   <= '0;
      sampCnt_q  <= '0;
      bitCnt_q   <= '0;
      smp_q      <= '0;
      shift_q    <= '0;
      parErr_q   <= 1'b0;
      frameErr_q <= 1'b0;
      brk_q      <= 1'b0;
      allZero_q  <= 1'b0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
      outFe_q    <= 1'b0;
      outPe_q    <= 1'b0;
      outBrk_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rxMeta_q   <= rx;
      rxs_q      <= rxMeta_q;
      divCnt_q   <= divCnt_d;
      sampCnt_q  <= sampCnt_d;
      bitCnt_q   <= bitCnt_d;
      smp_q      <= smp_d;
      shift_q    <= shift_d;
      parErr_q   <= parErr_d;
      frameErr_q <= frameErr_d;
      brk_q      <= brk_d;
      allZero_q  <= allZero_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
      outFe_q    <= outFe_d;
      outPe_q    <= outPe_d;
      outBrk_q   <= outBrk_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    divCnt_d   = tick ? '0 : divCnt_q + DIV_W'(1);
    sampCnt_d  = tick ? sampCnt_q + SC_W'(1) : sampCnt_q;
    bitCnt_d   = bitCnt_q;
    smp_d      = smp_q;
    shift_d    = shift_q;
    parErr_d   = parErr_q;
    frameErr_d = frameErr_q;
    brk_d      = brk_q;
    allZero_d  = allZero_q;
    done       = 1'b0;
    doneFe     = 1'b0;
    doneBrk    = 1'b0;

    if (tick && sampCnt_q == SMP_A) smp_d[0] = rxs_q;
    if (tick && sampCnt_q == SMP_B) smp_d[1] = rxs_q;

    case (state_q)
      S_IDLE: begin
        if (tick && !rxs_q) begin
          sampCnt_d  = '0;
          bitCnt_d   = '0;
          parErr_d   = 1'b0;
          frameErr_d = 1'b0;
          brk_d      = 1'b0;
          allZero_d  = 1'b1;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (decide && maj)  state_d = S_IDLE;
        else if (wrap)      state_d = S_DATA;
      end
      S_DATA: begin
        if (decide) begin
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
          if (maj) allZero_d = 1'b0;
        end
        if (wrap) begin
          if (bitCnt_q == DATA_LAST) begin
            bitCnt_d = '0;
            state_d  = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bitCnt_d = bitCnt_q + BC_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (decide) begin
          parErr_d = (PARITY == 2) ? ~(^shift_q ^ maj) : (^shift_q ^ maj);
          if (maj) allZero_d = 1'b0;
        end
        if (wrap) state_d = S_STOP;
      end
      S_STOP: begin
        // Completion is at the last stop decision so a back-to-back start bit is caught.
        if (decide) begin
          if (!maj) frameErr_d = 1'b1;
          if (bitCnt_q == '0) brk_d = allZero_q & ~maj;
          if (bitCnt_q == STOP_LAST) begin
            done    = 1'b1;
            doneFe  = frameErr_q | ~maj;
            doneBrk = (bitCnt_q == '0) ? (allZero_q & ~maj) : brk_q;
            state_d = doneBrk ? S_BRK : S_IDLE;
          end
        end else if (wrap) begin
          bitCnt_d = bitCnt_q + BC_W'(1);
        end
      end
      S_BRK: begin
        if (tick && rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    outData_d  = outData_q;
    outValid_d = outValid_q;
    outFe_d    = outFe_q;
    outPe_d    = outPe_q;
    outBrk_d   = outBrk_q;
    overrun_d  = 1'b0;

    if (done) begin
      if (!outValid_q || m_if.m_ready) begin
        outData_d  = doneBrk ? '0 : shift_q;
        outFe_d    = doneFe;
        outPe_d    = parErr_q;
        outBrk_d   = doneBrk;
        outValid_d = 1'b1;
      end else begin
        overrun_d  = 1'b1;
      end
    end else if (outValid_q && m_if.m_ready) begin
      outValid_d = 1'b0;
    end
  end

  assign m_if.m_data     = outData_q;
  assign m_if.m_valid    = outValid_q;
  assign m_if.frame_err  = outFe_q;
  assign m_if.parity_err = outPe_q;
  assign m_if.break_det  = outBrk_q;
  assign m_if.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: an 8N1 instance and a 7E2 instance share
// the clock and reset; frames are driven bit by bit at 32 clk per bit.
module tb_uart_rx_cfg;

  localparam int CLK_B   = 3686400;
  localparam int BAUD_B  = 115200;
  localparam int OVR_B   = 16;
  localparam int DIV_B   = 2;
  localparam int BIT_CLK = OVR_B * DIV_B;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx8 = 1'b1;
  logic rx7 = 1'b1;

  uart_rx_cfg_if #(.DATA_BITS(8)) if8 ();
  uart_rx_cfg_if #(.DATA_BITS(7)) if7 ();

  uart_rx_cfg #(
    .CLOCK_RATE(CLK_B), .BAUD_RATE(BAUD_B), .OVR(OVR_B),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut8 (
    .clk(clk), .rst_n(rst_n), .rx(rx8), .m_if(if8)
  );

  uart_rx_cfg #(
    .CLOCK_RATE(CLK_B), .BAUD_RATE(BAUD_B), .OVR(OVR_B),
    .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)
  ) dut7 (
    .clk(clk), .rst_n(rst_n), .rx(rx7), .m_if(if7)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int relCyc = 0;
  int nCompared = 0;
  int nMismatched = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observations of each stream, taken mid-cycle while outputs are stable.
  int         validCnt8 = 0, xferCnt8 = 0, ovrCnt8 = 0, riseCyc8 = 0;
  logic       prevValid8 = 1'b0;
  logic [7:0] lastData8 = '0, lastXfer8 = '0;
  logic       lastFe8 = 1'b0, lastPe8 = 1'b0, lastBrk8 = 1'b0;
  int         validCnt7 = 0;
  logic [6:0] lastData7 = '0;
  logic       lastFe7 = 1'b0, lastPe7 = 1'b0;

  always @(negedge clk) begin
    if (if8.m_valid === 1'b1) begin
      validCnt8++;
      lastData8 = if8.m_data;
      lastFe8   = if8.frame_err;
      lastPe8   = if8.parity_err;
      lastBrk8  = if8.break_det;
      if (!prevValid8) riseCyc8 = cyc;
      if (if8.m_ready) begin
        xferCnt8++;
        lastXfer8 = if8.m_data;
      end
    end
    if (if8.overrun === 1'b1) ovrCnt8++;
    prevValid8 = (if8.m_valid === 1'b1);
    if (if7.m_valid === 1'b1) begin
      validCnt7++;
      lastData7 = if7.m_data;
      lastFe7   = if7.frame_err;
      lastPe7   = if7.parity_err;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // bits[0] goes on the line first; called at posedge+1, returns at posedge+1.
  task automatic applyStimulus(input bit toSeven, input logic [15:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (toSeven) rx7 = bits[i];
      else         rx8 = bits[i];
      repeat (BIT_CLK) @(posedge clk);
      #1;
    end
    if (toSeven) rx7 = 1'b1;
    else         rx8 = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    relCyc = cyc;
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] frame8(input logic [7:0] d, input logic stopBit);
    return {6'b0, stopBit, d, 1'b0};
  endfunction

  function automatic logic [15:0] frame7e2(input logic [6:0] d, input logic p);
    return {5'b0, 2'b11, p, d, 1'b0};
  endfunction

  // Cycle on which m_valid is first seen high: the 2-flop synchroniser puts
  // the edge on rxs 2 clk after cycle e, detection waits for the next tick
  // (ticks fall on even offsets from the reset cycle), and the last stop
  // decision is OVR/2+2 ticks into frame bit lastBit.
  function automatic int expDone(input int e, input int lastBit);
    int d;
    d = e + 3;
    if (((d - relCyc) % DIV_B) != 0) d++;
    return d + DIV_B * (OVR_B * lastBit + OVR_B / 2 + 2);
  endfunction

  int v0, x0, o0, e0, expRise;

  initial begin
    if8.m_ready = 1'b1;
    if7.m_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    relCyc = cyc;
    rst_n = 1'b1;

    checkOutput("rst_valid",   if8.m_valid, 0);
    checkOutput("rst_data",    if8.m_data, 0);
    checkOutput("rst_fe",      if8.frame_err, 0);
    checkOutput("rst_pe",      if8.parity_err, 0);
    checkOutput("rst_brk",     if8.break_det, 0);
    checkOutput("rst_overrun", if8.overrun, 0);
    idle(40);

    $display("[TB] 8N1 frame 0xA5");
    v0 = validCnt8;
    e0 = cyc;
    expRise = expDone(e0, 9);
    applyStimulus(1'b0, frame8(8'hA5, 1'b1), 10);
    idle(64);
    checkOutput("a5_data",    lastData8, 8'hA5);
    checkOutput("a5_flags",   {lastFe8, lastPe8, lastBrk8}, 3'b000);
    checkOutput("a5_vcycles", validCnt8 - v0, 1);
    checkOutput("a5_latency", riseCyc8, expRise);

    $display("[TB] 7E2 parity");
    v0 = validCnt7;
    applyStimulus(1'b1, frame7e2(7'h41, 1'b0), 11);
    idle(64);
    checkOutput("7e2_ok_count", validCnt7 - v0, 1);
    checkOutput("7e2_ok_data",  lastData7, 7'h41);
    checkOutput("7e2_ok_pe",    lastPe7, 0);
    checkOutput("7e2_ok_fe",    lastFe7, 0);
    applyStimulus(1'b1, frame7e2(7'h41, 1'b1), 11);
    idle(64);
    checkOutput("7e2_bad_data", lastData7, 7'h41);
    checkOutput("7e2_bad_pe",   lastPe7, 1);

    $display("[TB] glitch and framing error");
    v0 = validCnt8;
    rx8 = 1'b0;
    idle(8);
    rx8 = 1'b1;
    idle(200);
    checkOutput("glitch_none", validCnt8 - v0, 0);
    applyStimulus(1'b0, frame8(8'h3C, 1'b1), 10);
    idle(64);
    checkOutput("3c_data",  lastData8, 8'h3C);
    checkOutput("3c_flags", {lastFe8, lastPe8, lastBrk8}, 3'b000);
    v0 = validCnt8;
    applyStimulus(1'b0, frame8(8'h0F, 1'b0), 10);
    idle(200);
    checkOutput("fe_count", validCnt8 - v0, 1);
    checkOutput("fe_data",  lastData8, 8'h0F);
    checkOutput("fe_flags", {lastFe8, lastBrk8}, 2'b10);

    $display("[TB] break");
    v0 = validCnt8;
    rx8 = 1'b0;
    idle(20 * BIT_CLK);
    rx8 = 1'b1;
    idle(64);
    checkOutput("brk_count", validCnt8 - v0, 1);
    checkOutput("brk_data",  lastData8, 8'h00);
    checkOutput("brk_flags", {lastFe8, lastBrk8}, 2'b11);
    applyStimulus(1'b0, frame8(8'h55, 1'b1), 10);
    idle(64);
    checkOutput("55_data",  lastData8, 8'h55);
    checkOutput("55_flags", {lastFe8, lastPe8, lastBrk8}, 3'b000);

    $display("[TB] overrun");
    if8.m_ready = 1'b0;
    o0 = ovrCnt8;
    x0 = xferCnt8;
    applyStimulus(1'b0, frame8(8'h11, 1'b1), 10);
    idle(64);
    applyStimulus(1'b0, frame8(8'h22, 1'b1), 10);
    idle(64);
    checkOutput("ovr_held_data",  if8.m_data, 8'h11);
    checkOutput("ovr_held_valid", if8.m_valid, 1);
    checkOutput("ovr_pulses",     ovrCnt8 - o0, 1);
    if8.m_ready = 1'b1;
    idle(8);
    checkOutput("ovr_xfers",     xferCnt8 - x0, 1);
    checkOutput("ovr_xfer_data", lastXfer8, 8'h11);
    checkOutput("ovr_drained",   if8.m_valid, 0);

    $display("[TB] ready in the completion cycle");
    if8.m_ready = 1'b0;
    applyStimulus(1'b0, frame8(8'h11, 1'b1), 10);
    idle(64);
    o0 = ovrCnt8;
    x0 = xferCnt8;
    e0 = cyc;
    expRise = expDone(e0, 9);
    fork
      applyStimulus(1'b0, frame8(8'h22, 1'b1), 10);
      begin
        while (cyc < expRise - 1) begin
          @(posedge clk);
          #1;
        end
        if8.m_ready = 1'b1;
        @(posedge clk);
        #1;
        if8.m_ready = 1'b0;
      end
    join
    idle(64);
    checkOutput("sim_data",      if8.m_data, 8'h22);
    checkOutput("sim_valid",     if8.m_valid, 1);
    checkOutput("sim_no_ovr",    ovrCnt8 - o0, 0);
    checkOutput("sim_xfer_data", lastXfer8, 8'h11);
    if8.m_ready = 1'b1;
    idle(8);
    checkOutput("sim_xfers",      xferCnt8 - x0, 2);
    checkOutput("sim_drain_data", lastXfer8, 8'h22);

    $display("[TB] reset mid-frame");
    v0 = validCnt8;
    e0 = cyc;
    fork
      applyStimulus(1'b0, frame8(8'hFF, 1'b1), 10);
      begin
        while (cyc < e0 + 4 * BIT_CLK + 12) begin
          @(posedge clk);
          #1;
        end
        pulseReset();
      end
    join
    idle(200);
    checkOutput("rst_frame_none", validCnt8 - v0, 0);
    e0 = cyc;
    expRise = expDone(e0, 9);
    applyStimulus(1'b0, frame8(8'h81, 1'b1), 10);
    idle(64);
    checkOutput("81_data",    lastData8, 8'h81);
    checkOutput("81_flags",   {lastFe8, lastPe8, lastBrk8}, 3'b000);
    checkOutput("81_latency", riseCyc8, expRise);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver that succeeds our fixed 8-bit/parity/1-stop receiver. Data width, parity mode, stop-bit count and oversampling ratio are configurable. Each received frame is delivered over a valid/ready stream interface with per-frame error flags, break detection and overrun reporting. It sits between the board RX pin and the command/FIFO logic in the iCE40 designs.

## Interface
- `CLOCK_RATE`, default 100000000: system clock in Hz.
- `BAUD_RATE`, default 115200: line rate in baud.
- `OVR`, default 16: oversampling ticks per bit. Must be a power of two, ≥ 8.
- `DATA_BITS`, default 8: data bits per frame, legal range 5..9.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: 1 or 2.
- `clk` input 1: system clock. This is the block's only clock.
- `rst_n` input 1: reset, synchronous and active-low.
- `rx` input 1: asynchronous serial line. Idle high.
- `m_data` output `DATA_BITS`: received word, LSB = first bit on the line.
- `m_valid` output 1: `m_data` and the flags below are valid.
- `m_ready` input 1: consumer accepts the word.
- `frame_err` output 1: a stop bit was sampled low. Qualified by `m_valid`.
- `parity_err` output 1: parity mismatch. Forced 0 when `PARITY=0`. Qualified by `m_valid`.
- `break_det` output 1: the frame was a line break. Qualified by `m_valid`.
- `overrun` output 1: one-cycle pulse when a completed frame is dropped.

## Operation
- **Synchroniser:** `rx` passes through 2 flops, both reset to 1. All logic uses the synchronised signal `rxs`.
- **Tick generator:**
  - `DIV = CLOCK_RATE/(BAUD_RATE*OVR)`.
  - The divider counter counts 0..DIV-1 and asserts `tick` for one cycle at DIV-1.
  - Counter width is `$clog2(DIV)`, minimum 1.
- **Sample counter:** 0..OVR-1, advances on `tick`.
- **Bit value:** majority of the three samples at counts OVR/2-1, OVR/2 and OVR/2+1, taken in the bit's own period. The bit is decided at count OVR/2+1 (the "decision tick").
- **FSM states:** IDLE, START, DATA, PARITY, STOP, BRK.
  - **IDLE:** on a tick with `rxs==0`, clear the sample counter and go to START.
  - **START:** at the decision tick, majority 1 means a false start: return to IDLE with no output. Majority 0 continues to DATA once the sample counter wraps.
  - **DATA:** shift the majority value in LSB-first, `DATA_BITS` bits. Then go to PARITY if `PARITY≠0`, else STOP.
  - **PARITY:**
    - Even mode: error if XOR(data, parity bit) = 1.
    - Odd mode: error if XOR(data, parity bit) = 0.
  - **STOP:** `STOP_BITS` periods. `frame_err` is set if any stop decision is 0. The frame completes at the decision tick of the last stop bit; there is no wait for end of bit, so the receiver can resync to a back-to-back start bit.
  - **BRK:** entered on completion when `break_det` is set. Stay until `rxs==1` on a tick, then go to IDLE.
- **Break:** all data bits, the parity bit (if present) and the first stop bit are 0. This sets `break_det=1` and `frame_err=1`, and `m_data=0`.
- **Output register, on frame completion:**
  - If `!m_valid`, or `m_valid && m_ready` in the same cycle: load data and flags, and set `m_valid=1`.
  - Otherwise (`m_valid && !m_ready`): keep the old word, drop the new frame, and pulse `overrun` for 1 cycle.
- `m_valid` clears on a cycle where `m_valid && m_ready` and no new frame completes.
- `m_data` and the flags are held stable while `m_valid && !m_ready`.

## Timing
- **Reset values:** `m_valid=0`, `m_data=0`, `frame_err=0`, `parity_err=0`, `break_det=0`, `overrun=0`. Synchroniser = 1, state = IDLE, all counters = 0.
- **Reset mid-frame:** the frame in progress is discarded and there is no output. Reception resumes on the next falling edge after release.
- **Latency:** `m_valid` rises exactly 1 clk after the tick that carries the last stop decision. Line-to-`rxs` delay is 2 clk.
- **Start alignment:** the start edge is detected within 1 tick of its arrival. Sampling error is ±1 tick out of OVR.
- **Handshake:** a word transfers on a rising `clk` with `m_valid && m_ready`.
  - `m_ready` may be held high permanently.
  - `m_ready` has no combinational path to any output.

## Test plan
Bench parameters: `CLOCK_RATE=3686400`, `BAUD_RATE=115200`, `OVR=16` (DIV=2, 32 clk/bit).

1. **Default 8N1 frame:** send 0xA5, `m_ready=1`. Expect `m_data=0xA5`, all flags 0, `m_valid` high for 1 clk, 1 clk after the stop decision tick.
2. **7E2 parity check:** `DATA_BITS=7`, `PARITY=1`, `STOP_BITS=2`. Send 0x41 with parity bit 0 → `parity_err=0`. Send 0x41 with parity bit 1 → `parity_err=1`, `m_data=0x41`.
3. **Glitch and framing error:**
   - A 0.25-bit (8 clk) low glitch on an idle line produces no `m_valid`, and the next 0x3C is received correctly.
   - A frame with stop bit 0 gives `frame_err=1`.
4. **Break:** hold `rx` low for 20 bit times, then high. Expect exactly one word with `m_data=0`, `break_det=1`, `frame_err=1`. The following 0x55 is received cleanly.
5. **Overrun and simultaneous completion:**
   - With `m_ready=0`, send 0x11 then 0x22. Expect `m_data` to stay 0x11 and one `overrun` pulse. Raise `m_ready` and expect a single transfer of 0x11.
   - Repeat with `m_ready` pulsed in the completion cycle of 0x22. Expect 0x22 loaded and no overrun.
6. **Reset mid-frame:** assert `rst_n=0` for 1 clk during data bit 3 of 0xFF. Expect no `m_valid` for that frame; the next 0x81 is received correctly.
